// File: rtl/sram_packet_driver_pkg.sv
// Shared definitions for the SRAM packet driver: packet field positions, idle packet, frame width, FSM states.
// Frame width grows by one parity bit when SRAM_PKT_PARITY_EN is defined.
package sram_pkt_pkg;

    localparam int ADDR0_MSB = 54;
    localparam int ADDR0_LSB = 47;
    localparam int WDATA_MSB = 46;
    localparam int WDATA_LSB = 15;
    localparam int WMASK_MSB = 14;
    localparam int WMASK_LSB = 11;
    localparam int WEB0_BIT  = 10;
    localparam int CSB0_BIT  = 9;
    localparam int ADDR1_MSB = 8;
    localparam int ADDR1_LSB = 1;
    localparam int CSB1_BIT  = 0;

    // Both ports deselected, port 0 in read mode, everything else zero.
    localparam logic [ADDR0_MSB:0] IDLE_PACKET =
        (55'd1 << WEB0_BIT) | (55'd1 << CSB0_BIT) | (55'd1 << CSB1_BIT);

`ifdef SRAM_PKT_PARITY_EN
    localparam int FRAME_W = ADDR0_MSB + 3;
`else
    localparam int FRAME_W = ADDR0_MSB + 2;
`endif
    localparam int PAY_LSB = FRAME_W - (ADDR0_MSB + 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        UNLOAD = 3'd4
    } state_t;

endpackage

// File: rtl/sram_packet_driver_if.sv
// Pin-side bundle of the SRAM packet driver; slave is the driver, master is the host/SRAM side.
// parity_err exists only when SRAM_PKT_PARITY_EN is defined.
interface sram_packet_driver_if #(
    parameter int PACKET_W = 55,
    parameter int DATA_W   = 32
);
    logic                scan_en;
    logic                scan_in;
    logic                ready;
    logic                chip_select;
    logic [PACKET_W-1:0] packet;
    logic [DATA_W-1:0]   read_data;
    logic                scan_out;
    logic                scan_out_valid;
    logic                done;
`ifdef SRAM_PKT_PARITY_EN
    logic                parity_err;

    modport slave (
        input  scan_en, scan_in, read_data,
        output ready, chip_select, packet, scan_out, scan_out_valid, done, parity_err
    );
    modport master (
        output scan_en, scan_in, read_data,
        input  ready, chip_select, packet, scan_out, scan_out_valid, done, parity_err
    );
`else
    modport slave (
        input  scan_en, scan_in, read_data,
        output ready, chip_select, packet, scan_out, scan_out_valid, done
    );
    modport master (
        output scan_en, scan_in, read_data,
        input  ready, chip_select, packet, scan_out, scan_out_valid, done
    );
`endif
endinterface

// File: rtl/sram_packet_driver_serializer.sv
// Read-data unloader: loads one word and shifts it out MSB first, one bit per cycle, flagging each bit valid.
module sram_pkt_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_bit,
    output logic              o_valid,
    output logic              o_last
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;

    always_ff @(posedge clk_in) begin
        if (i_load) begin
            r_sr <= i_data;
        end else if (r_valid) begin
            r_sr <= {r_sr[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_cnt   <= '0;
        end else if (r_valid) begin
            if (o_last) begin
                r_valid <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Gate with valid so the unreset data register never leaks onto the pin.
    assign o_bit   = r_valid & r_sr[DATA_W-1];
    assign o_valid = r_valid;
    assign o_last  = r_valid && (r_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/sram_packet_driver.sv
// Serial-to-packet front end for the testchip SRAM: shifts in a frame, issues it for one cycle, returns port-0 read data serially.
// Optional SRAM_PKT_PARITY_EN adds a trailing even-parity frame bit and a sticky parity_err output.
module sram_packet_driver
    import sram_pkt_pkg::*;
#(
    parameter int PACKET_W = 55,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    sram_packet_driver_if.slave  bus
);
    state_t              r_state;
    state_t              w_next;
    logic [FRAME_W-1:0]  r_frame;
    logic [5:0]          r_cnt;
    logic [2:0]          r_wcnt;
    logic [PACKET_W-1:0] r_packet;
    logic                r_cs;
    logic                r_done;
    logic                w_ready;
    logic                w_accept;
    logic                w_full;
    logic                w_par_ok;
    logic                w_p0_read;
    logic                w_load;
    logic                w_sbit;
    logic                w_svalid;
    logic                w_last;

    assign w_full    = (r_cnt == 6'(FRAME_W));
    assign w_ready   = (r_state == IDLE) || ((r_state == SHIFT) && !w_full);
    assign w_accept  = w_ready && bus.scan_en;
    assign w_p0_read = !r_packet[CSB0_BIT] && r_packet[WEB0_BIT];
    assign w_load    = (r_state == WAIT) && (r_wcnt == 3'(READ_LAT));

`ifdef SRAM_PKT_PARITY_EN
    logic r_perr;
    assign w_par_ok = ~^r_frame;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_perr <= 1'b0;
        end else if ((r_state == SHIFT) && w_full && !w_par_ok) begin
            r_perr <= 1'b1;
        end
    end
    assign bus.parity_err = r_perr;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = SHIFT;
            SHIFT:   if (w_full)   w_next = w_par_ok ? ISSUE : IDLE;
            ISSUE:   w_next = w_p0_read ? WAIT : IDLE;
            WAIT:    if (w_load)   w_next = UNLOAD;
            UNLOAD:  if (w_last)   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_frame <= {r_frame[FRAME_W-2:0], bus.scan_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt    <= '0;
            r_wcnt   <= '0;
            r_packet <= IDLE_PACKET;
            r_cs     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // Packet defaults back to idle, so a loaded frame is visible for exactly the ISSUE cycle.
            r_packet <= IDLE_PACKET;
            r_done   <= (w_next == IDLE) && (r_state != IDLE);
            if (w_next == IDLE) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if ((r_state == SHIFT) && w_full && w_par_ok) begin
                r_packet <= r_frame[PAY_LSB +: PACKET_W];
                r_cs     <= r_frame[FRAME_W-1];
            end
            // The ISSUE cycle counts as latency cycle 0.
            if (r_state == ISSUE) begin
                r_wcnt <= 3'd1;
            end else if ((r_state == WAIT) && !w_load) begin
                r_wcnt <= r_wcnt + 3'd1;
            end
        end
    end

    sram_pkt_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_load  (w_load),
        .i_data  (bus.read_data),
        .o_bit   (w_sbit),
        .o_valid (w_svalid),
        .o_last  (w_last)
    );

    assign bus.ready          = w_ready;
    assign bus.chip_select    = r_cs;
    assign bus.packet         = r_packet;
    assign bus.scan_out       = w_sbit;
    assign bus.scan_out_valid = w_svalid;
    assign bus.done           = r_done;

endmodule

// File: doc/sram_packet_driver.md
Name: sram_packet_driver

Overview:
- Host-side end of the testchip SRAM packet interface.
- Deserialises a GPIO-driven serial frame into a chip_select bit plus a 55-bit packet, and issues that packet for exactly one cycle to the SRAM input controller.
- On a port-0 read, waits out the SRAM read latency, captures the 32-bit muxed read data and serialises it back out.
- Lets the chip be exercised from a handful of pins instead of 55 parallel wires.

Parameters:
- PACKET_W, 55: packet width presented to the SRAM input controller.
- DATA_W, 32: read-data width returned by the SRAM output mux.
- READ_LAT, 2: cycles from packet issue to valid read_data; legal range 1..7.

Ports:
- clk_in  in  1  system clock; also the SRAM clock.
- rst_in  in  1  synchronous, active-high reset.
- scan_en  in  1  qualifies scan_in; one bit is accepted per cycle while high and ready.
- scan_in  in  1  serial frame bit, MSB first.
- ready  out  1  high in IDLE/SHIFT; frame bits are accepted only when high.
- chip_select  out  1  SRAM select to the input controller and output mux.
- packet  out  PACKET_W  packet to the input controller.
- read_data  in  DATA_W  muxed SRAM read data.
- scan_out  out  1  serial read data, MSB first.
- scan_out_valid  out  1  high while scan_out carries a data bit.
- done  out  1  one-cycle pulse at the end of every transaction.

Behaviour:
- Frame format: 1+PACKET_W = 56 bits, sent MSB first.
  - bit55: chip_select.
  - bits54:0: packet fields, top to bottom: addr0[7:0], wdata[31:0], wmask[3:0], web0, csb0, addr1[7:0], csb1.
- IDLE_PACKET: csb0=1, csb1=1, web0=1, all other fields 0.
- Reset values: packet=IDLE_PACKET, chip_select=0, ready=1, scan_out=0, scan_out_valid=0, done=0, bit counter=0, state=IDLE.
- IDLE: the first accepted bit goes to SHIFT.
- SHIFT:
  - Each accepted bit shifts into a 56-bit frame register; the counter increments.
  - scan_en low pauses shifting; no data is lost and there is no timeout.
  - At count 56 the next state is ISSUE and ready drops in the same cycle.
- ISSUE:
  - chip_select and packet take the frame for exactly 1 cycle.
  - The following cycle, packet returns to IDLE_PACKET; chip_select holds its issued value until the next ISSUE.
  - Port-0 read (csb0=0, web0=1): go to WAIT.
  - Anything else (write, port-1 read, no-op): pulse done, return to IDLE.
  - Port-1 read data is not returned.
- WAIT:
  - Counts READ_LAT cycles, counted from the ISSUE cycle.
  - Then read_data is latched into a 32-bit shift register.
  - Go to UNLOAD.
- UNLOAD:
  - 32 cycles with scan_out_valid=1, scan_out = shift-register MSB, shifting left each cycle.
  - After bit 0: scan_out_valid=0, done pulses, go to IDLE.
- Readiness: ready=0 in ISSUE/WAIT/UNLOAD. scan_en/scan_in are ignored then; no back-pressure queue exists.
- Reset mid-operation: next edge restores all reset values. A partial frame or unload is discarded; packet returns to IDLE_PACKET immediately.
- scan_en asserted in the same cycle ready falls: that bit is ignored.
- Counters wrap-free: frame count 0..56, unload count 0..31, both cleared on each IDLE entry.

Optional Feature:
- SRAM_PKT_PARITY_EN defined:
  - Frame grows to 57 bits; the last bit is even parity over the preceding 56.
  - On mismatch, ISSUE is skipped: packet stays IDLE_PACKET and chip_select is unchanged.
  - A sticky output parity_err (1 bit, reset 0, cleared only by rst_in) sets; done pulses and the block returns to IDLE.
- Undefined: 56-bit frame, no parity_err port.

Decomposition:
- Package sram_pkt_pkg holds:
  - field bit-position localparams (ADDR0_MSB..CSB1_BIT);
  - IDLE_PACKET;
  - FRAME_W;
  - state encoding (IDLE, SHIFT, ISSUE, WAIT, UNLOAD).
- One sub-module, sram_pkt_serializer: the 32-bit load/shift-out register with its counter and scan_out_valid. Deserialisation and the FSM stay in the top.

Test Plan:
- Reset: assert rst_in mid-SHIFT after 20 bits → packet=IDLE_PACKET, ready=1; a fresh 56-bit frame then issues correctly.
- Write: frame cs=0, addr0=0x12, wdata=0xDEADBEEF, wmask=0xF, web0=0, csb0=0 → packet matches for exactly 1 cycle, done pulses, no scan_out_valid. A subsequent read of 0x12 returns 0xDEADBEEF.
- Read SRAM1: write 0xA5A5_0F0F at addr 0x80 with cs=1, then read it back → after READ_LAT, 32 scan_out bits equal 0xA5A50F0F MSB first, and 0x80 in SRAM0 is unaffected.
- Paused shift: toggle scan_en low for 5 cycles every 8 bits → the issued packet equals the frame; issue happens only after the 56th accepted bit.
- Busy: drive scan_en=1 with random scan_in during WAIT/UNLOAD → bits are ignored; the next frame after done is received intact.
- Parity (SRAM_PKT_PARITY_EN): send a write frame with a flipped parity bit → no issue, parity_err=1, done pulses; a correct frame afterwards issues normally with parity_err still 1.
